// File: rtl/mem_write_router_if.sv
// Bus bundle for mem_write_router: one write-data input stream fanning out
// to NUM_CH valid/ready memory-side channels, plus error status.
interface mem_write_router_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 3
);
    localparam int unsigned SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        ch_full;
    logic                     err;
    logic [7:0]               err_cnt;

    // Producer/consumer side of the router
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, ch_full, err, err_cnt
    );

    // Router side
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, ch_full, err, err_cnt
    );
endinterface

// File: rtl/mem_write_router.sv
// Buffered 1-to-NUM_CH write-data router with a DEPTH-entry FIFO per channel.
// Optional broadcast on the all-ones select is enabled by MEM_ROUTER_BCAST_EN.
module mem_write_router #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_write_router_if.slave   bus
);
    localparam int unsigned SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
`ifdef MEM_ROUTER_BCAST_EN
    localparam bit BCAST_OK = ((1 << SEL_W) > NUM_CH);
`endif

    logic [DATA_W-1:0] mem_q     [NUM_CH][DEPTH];
    logic [DATA_W-1:0] mem_d     [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q  [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d  [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q  [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d  [NUM_CH];
    logic [NUM_CH-1:0] full_q, full_d;
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [NUM_CH-1:0] ch_ok;
    logic [NUM_CH-1:0] sel_hit;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              sel_valid;
    logic              is_bcast;
    logic              accept;

    // Select decode and input handshake; a full channel still accepts if it pops now
    always_comb begin
        ch_ok     = ~full_q | bus.out_ready;
        sel_valid = {1'b0, bus.in_sel} < (SEL_W + 1)'(NUM_CH);
        sel_hit   = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            sel_hit[i] = (bus.in_sel == SEL_W'(i));
        end
        is_bcast = 1'b0;
`ifdef MEM_ROUTER_BCAST_EN
        is_bcast = BCAST_OK && (&bus.in_sel);
`else
        is_bcast = 1'b0;
`endif
        if (sel_valid) begin
            bus.in_ready = |(sel_hit & ch_ok);
        end else if (is_bcast) begin
            bus.in_ready = &ch_ok;
        end else begin
            bus.in_ready = 1'b1;
        end
        accept = bus.in_valid && bus.in_ready;
        push   = {NUM_CH{accept}} & (sel_hit | {NUM_CH{is_bcast}});
        pop    = valid_q & bus.out_ready;
    end

    // Per-channel FIFO next state; occupancy is implicit in the pointer pair
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = '0;
        valid_d  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i][AW-1:0]] = bus.in_data;
            end
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            full_d[i]   = (wr_ptr_d[i][AW] != rd_ptr_d[i][AW]) &&
                          (wr_ptr_d[i][AW-1:0] == rd_ptr_d[i][AW-1:0]);
            valid_d[i]  = (wr_ptr_d[i] != rd_ptr_d[i]);
        end
    end

    // Dropped-word error pulse and saturating counter
    always_comb begin
        err_d     = accept && !sel_valid && !is_bcast;
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            full_q    <= '0;
            valid_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: heads are only exposed behind valid_q
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Outputs; idle channels present zeros rather than stale storage
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            bus.out_data[i*DATA_W +: DATA_W] =
                valid_q[i] ? mem_q[i][rd_ptr_q[i][AW-1:0]] : '0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.ch_full   = full_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mem_write_router.sv
// Directed bench for mem_write_router (DATA_W=16, NUM_CH=3, DEPTH=4).
module tb_mem_write_router;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mem_write_router_if #(.DATA_W(16), .NUM_CH(3)) bus ();

    mem_write_router #(.DATA_W(16), .NUM_CH(3), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset held two cycles with a word on the input
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 16'hffff;
        bus.out_ready = 3'b000;
        tick();
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'd0;
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'h0);
        check("rst_data",  64'(bus.out_data),  64'h0);
        check("rst_full",  64'(bus.ch_full),   64'h0);
        check("rst_err",   64'(bus.err),       64'h0);
        check("rst_cnt",   64'(bus.err_cnt),   64'h0);
        check("rst_rdy",   64'(bus.in_ready),  64'h1);

        // Single word to channel 1
        bus.out_ready = 3'b111;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 16'hA5A5;
        tick();
        bus.in_valid = 1'b0;
        check("route_valid", 64'(bus.out_valid), 64'h2);
        check("route_data",  64'(bus.out_data),  64'(48'h0000_A5A5_0000));
        tick();
        check("route_drain", 64'(bus.out_valid), 64'h0);

        // Fill channel 0 while stalled
        bus.out_ready = 3'b110;
        for (int k = 1; k <= 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'd0;
            bus.in_data  = 16'(k);
            #1;
            check("bp_rdy", 64'(bus.in_ready), 64'h1);
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_full", 64'(bus.ch_full), 64'h1);
        bus.in_valid = 1'b1;
        #1;
        check("bp_block", 64'(bus.in_ready), 64'h0);
        bus.in_sel  = 2'd2;
        bus.in_data = 16'hBEEF;
        #1;
        check("iso_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = 1'b0;
        check("iso_valid", 64'(bus.out_valid), 64'h5);
        check("iso_data",  64'(bus.out_data),  64'(48'hBEEF_0000_0001));

        // Release channel 0 and drain in order
        bus.out_ready = 3'b111;
        for (int k = 1; k <= 4; k++) begin
            check("drain_head",  64'(bus.out_data[15:0]), 64'(k));
            check("drain_valid", 64'(bus.out_valid[0]),   64'h1);
            tick();
        end
        check("drain_empty", 64'(bus.out_valid), 64'h0);

        // Push into a full channel that is popping in the same cycle
        bus.out_ready = 3'b110;
        for (int k = 1; k <= 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'd0;
            bus.in_data  = 16'(k);
            tick();
        end
        bus.out_ready = 3'b111;
        bus.in_data   = 16'h0005;
        #1;
        check("fp_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = 1'b0;
        check("fp_full", 64'(bus.ch_full), 64'h1);
        for (int k = 2; k <= 5; k++) begin
            check("fp_head", 64'(bus.out_data[15:0]), 64'(k));
            tick();
        end
        check("fp_empty", 64'(bus.out_valid), 64'h0);

`ifndef MEM_ROUTER_BCAST_EN
        // Out-of-range select is dropped and counted
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd3;
        bus.in_data  = 16'h1234;
        #1;
        check("inv_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = 1'b0;
        check("inv_err",   64'(bus.err),       64'h1);
        check("inv_cnt",   64'(bus.err_cnt),   64'h1);
        check("inv_valid", 64'(bus.out_valid), 64'h0);
        tick();
        check("inv_err_clr", 64'(bus.err), 64'h0);
        bus.in_valid = 1'b1;
        repeat (300) tick();
        check("sat_cnt", 64'(bus.err_cnt), 64'd255);
        check("sat_err", 64'(bus.err),     64'h1);
        bus.in_valid = 1'b0;
        tick();
        check("sat_hold", 64'(bus.err_cnt), 64'd255);
        check("sat_clr",  64'(bus.err),     64'h0);
`else
        // All-ones select broadcasts to every channel
        bus.out_ready = 3'b000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd3;
        bus.in_data   = 16'h1234;
        #1;
        check("bc_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = 1'b0;
        check("bc_valid", 64'(bus.out_valid), 64'h7);
        check("bc_data",  64'(bus.out_data),  64'(48'h1234_1234_1234));
        check("bc_err",   64'(bus.err),       64'h0);
        for (int k = 1; k <= 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'd1;
            bus.in_data  = 16'(16'h0B00 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        check("bc_full", 64'(bus.ch_full), 64'h2);
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd3;
        bus.in_data  = 16'h9999;
        #1;
        check("bc_block", 64'(bus.in_ready), 64'h0);
        tick();
        bus.in_valid = 1'b0;
        check("bc_nopush_full", 64'(bus.ch_full),  64'h2);
        check("bc_nopush_data", 64'(bus.out_data), 64'(48'h1234_1234_1234));
        check("bc_nopush_err",  64'(bus.err),      64'h0);
        bus.out_ready = 3'b111;
        repeat (4) tick();
        check("bc_drain", 64'(bus.out_valid), 64'h0);
`endif

        // Reset mid-operation discards buffered words
        bus.out_ready = 3'b000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 16'h00AA;
        tick();
        bus.in_sel  = 2'd2;
        bus.in_data = 16'h00BB;
        tick();
        bus.in_valid = 1'b0;
        check("mr_pre", 64'(bus.out_valid), 64'h5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", 64'(bus.out_valid), 64'h0);
        check("mr_data",  64'(bus.out_data),  64'h0);
        check("mr_cnt",   64'(bus.err_cnt),   64'h0);
        bus.out_ready = 3'b111;
        tick();
        check("mr_stay", 64'(bus.out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
